// File: rtl/multiplicador_pkg.sv
// Shared encodings for the shift-and-add multiplier controller: datapath commands, FSM states, default width.
// No logic of its own; helpers decode a state into its registered output values.
package multiplicador_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef logic [2:0] ctrl_t;

    localparam ctrl_t CTRL_HOLD  = 3'b000;
    localparam ctrl_t CTRL_LOAD  = 3'b100;
    localparam ctrl_t CTRL_ADD   = 3'b010;
    localparam ctrl_t CTRL_SHIFT = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_ADD,
        ST_SHIFT,
        ST_FINISH,
        ST_CLEAR
    } state_t;

    function automatic ctrl_t ctrl_of(input state_t s);
        case (s)
            ST_LOAD:  return CTRL_LOAD;
            ST_ADD:   return CTRL_ADD;
            ST_SHIFT: return CTRL_SHIFT;
            default:  return CTRL_HOLD;
        endcase
    endfunction

    function automatic logic busy_of(input state_t s);
        return s inside {ST_LOAD, ST_CHECK, ST_ADD, ST_SHIFT, ST_CLEAR};
    endfunction

endpackage

// File: rtl/multiplicador_control_if.sv
// Request/abort, datapath feedback and command/status bundle between the multiplier controller and its users.
// slave = controller side; master = requester plus datapath side.
interface multiplicador_control_if;
    logic       Start;
    logic       Abort;
    logic       LSBB;
    logic       DpDone;
    logic [2:0] Control;
    logic       DpRun;
    logic       Busy;
    logic       Ready;

    modport master (
        output Start, Abort, LSBB, DpDone,
        input  Control, DpRun, Busy, Ready
    );

    modport slave (
        input  Start, Abort, LSBB, DpDone,
        output Control, DpRun, Busy, Ready
    );
endinterface

// File: rtl/mult_iter_counter.sv
// Saturating shift-iteration counter with sync clear; term flags an increment that lands on WIDTH.
// Latency: count updates on the clock edge; term is combinational on the current count and inc.
module mult_iter_counter #(
    parameter int WIDTH = 3
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clr,
    input  logic inc,
    output logic term
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;

    assign count_inc = (count == CW'(WIDTH)) ? count : count + CW'(1);
    assign term      = inc && (count_inc == CW'(WIDTH));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/multiplicador_control.sv
// Sequencer for the shift-and-add multiplier datapath: Start -> LOAD/CHECK/ADD/SHIFT -> one-cycle Ready.
// Latency 3 + 2k + popcount(B) cycles; Start only sampled in IDLE, Abort diverts to a one-cycle datapath clear.
module multiplicador_control
    import multiplicador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    multiplicador_control_if.slave bus
);

    state_t state;
    state_t next_state;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   cnt_term;

    ctrl_t  control_q;
    logic   dprun_q;
    logic   busy_q;
    logic   ready_q;

    mult_iter_counter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .Clock (Clock),
        .Reset (Reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .term  (cnt_term)
    );

    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.Start) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                cnt_clr    = 1'b1;
                next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (bus.DpDone)    next_state = ST_FINISH;
                else if (bus.LSBB) next_state = ST_ADD;
                else               next_state = ST_SHIFT;
            end
            ST_ADD: begin
                next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                // DpDone already reflects this shift; the guard only trips when B never drains.
                cnt_inc    = 1'b1;
                next_state = (cnt_term && !bus.DpDone) ? ST_FINISH : ST_CHECK;
            end
            ST_FINISH: next_state = ST_IDLE;
            ST_CLEAR:  next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
        if (bus.Abort && (state inside {ST_LOAD, ST_CHECK, ST_ADD, ST_SHIFT})) begin
            next_state = ST_CLEAR;
        end
    end

    // Outputs are registered copies of the next state's decode, so they stay free of input paths.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            control_q <= CTRL_HOLD;
            dprun_q   <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state     <= next_state;
            control_q <= ctrl_of(next_state);
            dprun_q   <= (next_state != ST_CLEAR);
            busy_q    <= busy_of(next_state);
            ready_q   <= (next_state == ST_FINISH);
        end
    end

    assign bus.Control = control_q;
    assign bus.DpRun   = dprun_q;
    assign bus.Busy    = busy_q;
    assign bus.Ready   = ready_q;

endmodule

// File: tb/tb_multiplicador_control.sv
// Bench for multiplicador_control with a behavioural 3x3 shift-and-add datapath and a per-cycle expectation queue.
module tb_multiplicador_control;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multiplicador_control_if bus();

    multiplicador_control #(.WIDTH(3)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] ctrl;
        logic       busy;
        logic       ready;
        logic       dprun;
        logic [5:0] res;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         op_cyc = 0;
    int         last_lat = 0;
    logic [5:0] last_res = '0;
    bit         chk_en = 1'b0;
    bit         force_nodone = 1'b0;
    logic [2:0] a_in = '0;
    logic [2:0] b_in = '0;
    logic [5:0] dp_a = '0;
    logic [5:0] dp_p = '0;
    logic [2:0] dp_b = '0;
    logic [2:0] trace [16];

    // Datapath: acts on the negedge following each Control change.
    always @(negedge clk) begin
        if (!bus.DpRun) begin
            dp_a <= '0; dp_b <= '0; dp_p <= '0;
        end else begin
            case (bus.Control)
                3'b100: begin dp_a <= {3'b000, a_in}; dp_b <= b_in; dp_p <= '0; end
                3'b010: dp_p <= dp_p + dp_a;
                3'b001: begin dp_a <= dp_a << 1; dp_b <= dp_b >> 1; end
                default: ;
            endcase
        end
    end
    assign bus.LSBB   = dp_b[0];
    assign bus.DpDone = force_nodone ? 1'b0 : (dp_b == 3'b000);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] c, input logic b, input logic r,
                                input logic d, input logic [5:0] res);
        exp_t e;
        e.ctrl = c; e.busy = b; e.ready = r; e.dprun = d; e.res = res;
        return e;
    endfunction

    // Expected per-cycle behaviour of one operation from B alone: one check per remaining bit,
    // an add for each set bit, a shift per bit, then the final check and the Ready cycle.
    task automatic push_op(input int a, input int b);
        int bb = b;
        exp_q.push_back(mk(3'b100, 1'b1, 1'b0, 1'b1, 6'd0));
        while (bb != 0) begin
            exp_q.push_back(mk(3'b000, 1'b1, 1'b0, 1'b1, 6'd0));
            if (bb % 2 == 1) exp_q.push_back(mk(3'b010, 1'b1, 1'b0, 1'b1, 6'd0));
            exp_q.push_back(mk(3'b001, 1'b1, 1'b0, 1'b1, 6'd0));
            bb = bb / 2;
        end
        exp_q.push_back(mk(3'b000, 1'b1, 1'b0, 1'b1, 6'd0));
        exp_q.push_back(mk(3'b000, 1'b0, 1'b1, 1'b1, 6'(a * b)));
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(3'b000, 1'b0, 1'b0, 1'b1, 6'd0));
    endtask

    task automatic begin_op(input logic [2:0] a, input logic [2:0] b);
        @(negedge clk); #2;
        a_in = a; b_in = b;
        last_lat = 0; last_res = 6'h3f; op_cyc = 0;
    endtask

    task automatic fire();
        bus.Start = 1'b1;
        @(posedge clk); #2;
        bus.Start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Compare process: one sample per cycle, 1 ns after the negedge datapath update.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #1;
            op_cyc++;
            if (op_cyc < 16) trace[op_cyc] = bus.Control;
            if (bus.Ready === 1'b1) begin
                last_lat = op_cyc;
                last_res = dp_p;
            end
            if (chk_en) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("cycle", 32'({bus.Control, bus.Busy, bus.Ready, bus.DpRun}),
                                   32'({e.ctrl, e.busy, e.ready, e.dprun}));
                    if (e.ready) check("result", 32'(dp_p), 32'(e.res));
                end else begin
                    check("idle_no_ready", 32'(bus.Ready), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [2:0] lit3 [9] = '{3'b100, 3'b000, 3'b010, 3'b001, 3'b000, 3'b010, 3'b001, 3'b000, 3'b000};
    logic [2:0] litf [9] = '{3'b100, 3'b000, 3'b010, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000};

    initial begin
        bus.Start = 1'b0;
        bus.Abort = 1'b0;

        // Reset state
        #1;
        check("rst_control", 32'(bus.Control), 32'd0);
        check("rst_dprun",   32'(bus.DpRun),   32'd0);
        check("rst_busy",    32'(bus.Busy),    32'd0);
        check("rst_ready",   32'(bus.Ready),   32'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check("dprun_after_reset", 32'(bus.DpRun), 32'd1);
        chk_en = 1'b1;

        // A=5, B=3
        begin_op(3'd5, 3'd3); push_op(5, 3); push_idle(2); fire();
        wait_drain("b3");
        check("lat_b3", 32'(last_lat), 32'd9);
        check("res_b3", 32'(last_res), 32'd15);
        for (int i = 0; i < 9; i++) check("trace_b3", 32'(trace[i+1]), 32'(lit3[i]));

        // A=7, B=0
        begin_op(3'd7, 3'd0); push_op(7, 0); push_idle(2); fire();
        wait_drain("b0");
        check("lat_b0", 32'(last_lat), 32'd3);
        check("res_b0", 32'(last_res), 32'd0);

        // A=7, B=7
        begin_op(3'd7, 3'd7); push_op(7, 7); push_idle(2); fire();
        wait_drain("b7");
        check("lat_b7", 32'(last_lat), 32'd12);
        check("res_b7", 32'(last_res), 32'd49);

        // A=2, B=4
        begin_op(3'd2, 3'd4); push_op(2, 4); push_idle(2); fire();
        wait_drain("b4");
        check("lat_b4", 32'(last_lat), 32'd10);
        check("res_b4", 32'(last_res), 32'd8);

        // Abort in the first ADD of A=6, B=5
        begin_op(3'd6, 3'd5);
        exp_q.push_back(mk(3'b100, 1'b1, 1'b0, 1'b1, 6'd0));
        exp_q.push_back(mk(3'b000, 1'b1, 1'b0, 1'b1, 6'd0));
        exp_q.push_back(mk(3'b010, 1'b1, 1'b0, 1'b1, 6'd0));
        exp_q.push_back(mk(3'b000, 1'b1, 1'b0, 1'b0, 6'd0));
        push_idle(2);
        fire();
        @(posedge clk);
        @(posedge clk); #2;
        bus.Abort = 1'b1;
        @(posedge clk); #2;
        bus.Abort = 1'b0;
        wait_drain("abort");
        check("abort_result", 32'(dp_p), 32'd0);
        check("abort_no_ready", 32'(last_lat), 32'd0);

        // Start held across A=2,B=2 then A=3,B=1
        begin_op(3'd2, 3'd2);
        push_op(2, 2); push_idle(1); push_op(3, 1); push_idle(2);
        bus.Start = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #2; a_in = 3'd3; b_in = 3'd1;
        repeat (7) @(posedge clk);
        #2; bus.Start = 1'b0;
        wait_drain("b2b");
        check("res_b2b_second", 32'(last_res), 32'd3);

        // Stuck DpDone with B=1: guard ends after three shifts; Start pulses while busy are ignored
        force_nodone = 1'b1;
        begin_op(3'd5, 3'd1);
        for (int i = 0; i < 9; i++)
            exp_q.push_back(mk(litf[i], i < 8, i == 8, 1'b1, (i == 8) ? 6'd5 : 6'd0));
        push_idle(2);
        fire();
        repeat (2) @(posedge clk);
        #2; bus.Start = 1'b1;
        repeat (3) @(posedge clk);
        #2; bus.Start = 1'b0;
        wait_drain("guard");
        check("lat_guard", 32'(last_lat), 32'd9);
        check("res_guard", 32'(last_res), 32'd5);
        force_nodone = 1'b0;

        // Reset in the middle of the first SHIFT of A=5, B=7
        begin_op(3'd5, 3'd7); push_op(5, 7); fire();
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_shift", 32'(bus.Control), 32'(3'b001));
        #1;
        rst = 1'b1; chk_en = 1'b0; exp_q.delete();
        #1;
        check("mid_rst_control", 32'(bus.Control), 32'd0);
        check("mid_rst_dprun",   32'(bus.DpRun),   32'd0);
        check("mid_rst_busy",    32'(bus.Busy),    32'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst", 32'({bus.Control, bus.Busy, bus.Ready, bus.DpRun}), 32'(6'b000_0_0_1));
        check("post_rst_cleared", 32'(dp_p), 32'd0);
        chk_en = 1'b1;

        // Normal operation after reset: A=3, B=5
        begin_op(3'd3, 3'd5); push_op(3, 5); push_idle(2); fire();
        wait_drain("b5");
        check("lat_b5", 32'(last_lat), 32'd11);
        check("res_b5", 32'(last_res), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
